// File: rtl/n64_joybus_host.sv
// n64_joybus_host -- host side of the N64 Joybus controller protocol.
// The CPU loads CMD/ADDR and a TX payload over an 8-bit register bus, then
// writes CTRL to start one transaction. The transaction runs on the lowest
// enabled joy line. Reply bytes land in an RX FIFO that the CPU pops at
// address 5.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   joy1..joy4         open-drain lines (driven 0 or released)
//   address, ce, write register access strobe/select/direction
//   data_in_bus        write data
//   data_out_bus       registered read data
module n64_joybus_host #(
  parameter int QUARTER = 16,
  parameter int TIMEOUT = 512
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        joy1,
  inout  wire        joy2,
  inout  wire        joy3,
  inout  wire        joy4,
  input  logic [3:0] address,
  input  logic [7:0] data_in_bus,
  input  logic       write,
  input  logic       ce,
  output logic [7:0] data_out_bus
);

  localparam int MAXC  = (TIMEOUT > 4*QUARTER) ? TIMEOUT : 4*QUARTER;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] C_BIT  = CNT_W'(4*QUARTER - 1);
  localparam logic [CNT_W-1:0] C_STOP = CNT_W'(3*QUARTER - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(2*QUARTER - 1);
  localparam logic [CNT_W-1:0] C_TO   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_Q    = CNT_W'(QUARTER);
  localparam logic [CNT_W-1:0] C_3Q   = CNT_W'(3*QUARTER);

  typedef enum logic [2:0] {S_IDLE, S_TX_BIT, S_TX_STOP, S_RX_WAIT, S_RX_BIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]       byte_idx_q, byte_idx_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d;
  logic [7:0]       tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d, done_q, done_d, nores_q, nores_d;
  logic             bad_q, bad_d, ovf_q, ovf_d;
  logic [1:0]       port_q, port_d;
  logic [7:0]       cmd_q, cmd_d, addr_hi_q, addr_hi_d, addr_lo_q, addr_lo_d;
  logic [7:0]       dout_q, dout_d;
  logic [4:0]       tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [5:0]       tx_cnt_q, tx_cnt_d;
  logic [5:0]       rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [2:0]       sync_q, sync_d;

  logic [7:0] tx_mem [32];
  logic [7:0] rx_mem [33];

  logic       tx_push, tx_pop, tx_flush, rx_we;
  logic [7:0] rx_wd, rd_data;
  logic [5:0] nxt_idx;
  logic       line_in, drive_low, fall;
  logic [3:0] drv;

  // Open drain: only ever pull low; reset releases all lines immediately.
  assign joy1 = drv[0] ? 1'b0 : 1'bz;
  assign joy2 = drv[1] ? 1'b0 : 1'bz;
  assign joy3 = drv[2] ? 1'b0 : 1'bz;
  assign joy4 = drv[3] ? 1'b0 : 1'bz;
  assign data_out_bus = dout_q;

  always_comb begin
    case (port_q)
      2'd0:    line_in = joy1;
      2'd1:    line_in = joy2;
      2'd2:    line_in = joy3;
      default: line_in = joy4;
    endcase
  end

  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      S_TX_BIT:  drive_low = (cyc_q < (tx_sr_q[7] ? C_Q : C_3Q));
      S_TX_STOP: drive_low = (cyc_q < C_Q);
      default:   drive_low = 1'b0;
    endcase
    drv = '0;
    if (drive_low && !reset) drv[port_q] = 1'b1;
  end

  // sync_q[1] is the synchronised line, sync_q[2] its previous value.
  assign fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    state_d = state_q;   cyc_d = cyc_q;         bit_cnt_d = bit_cnt_q;
    byte_idx_d = byte_idx_q; tx_len_d = tx_len_q; rx_len_d = rx_len_q;
    tx_sr_d = tx_sr_q;   rx_sr_d = rx_sr_q;     pend_d = pend_q;
    busy_d = busy_q;     done_d = done_q;       nores_d = nores_q;
    bad_d = bad_q;       ovf_d = ovf_q;         port_d = port_q;
    cmd_d = cmd_q;       addr_hi_d = addr_hi_q; addr_lo_d = addr_lo_q;
    dout_d = dout_q;     tx_rd_d = tx_rd_q;     tx_wr_d = tx_wr_q;
    tx_cnt_d = tx_cnt_q; rx_rd_d = rx_rd_q;     rx_wr_d = rx_wr_q;
    sync_d = {sync_q[1:0], line_in};
    tx_push = 1'b0; tx_pop = 1'b0; tx_flush = 1'b0;
    rx_we = 1'b0;   rx_wd = 8'h00; nxt_idx = 6'(byte_idx_q + 6'd1);

    // CPU reads
    case (address)
      4'd0:    rd_data = cmd_q;
      4'd1:    rd_data = addr_hi_q;
      4'd2:    rd_data = addr_lo_q;
      4'd3:    rd_data = {1'b0, port_q, ovf_q, bad_q, nores_q, done_q, busy_q};
      4'd5:    rd_data = (rx_rd_q != rx_wr_q) ? rx_mem[rx_rd_q] : 8'h00;
      default: rd_data = 8'h00;
    endcase
    if (ce && !write) begin
      dout_d = rd_data;
      if (address == 4'd5 && rx_rd_q != rx_wr_q) rx_rd_d = 6'(rx_rd_q + 6'd1);
    end

    // CPU writes
    if (ce && write) begin
      case (address)
        4'd0: cmd_d = data_in_bus;
        4'd1: addr_hi_d = data_in_bus;
        4'd2: addr_lo_d = data_in_bus;
        4'd6: if (tx_cnt_q == 6'd32) ovf_d = 1'b1; else tx_push = 1'b1;
        4'd4: if (!busy_q && data_in_bus[3:0] != 4'd0) begin
          casez (data_in_bus[3:0])
            4'b???1: port_d = 2'd0;
            4'b??10: port_d = 2'd1;
            4'b?100: port_d = 2'd2;
            default: port_d = 2'd3;
          endcase
          done_d = 1'b0; nores_d = 1'b0; bad_d = 1'b0; ovf_d = 1'b0;
          rx_rd_d = '0; rx_wr_d = '0;
          cyc_d = '0; bit_cnt_d = '0; byte_idx_d = '0; tx_sr_d = cmd_q;
          busy_d = 1'b1; state_d = S_TX_BIT;
          case (cmd_q)
            8'h00, 8'hFF: begin tx_len_d = 6'd1;  rx_len_d = 6'd3;  end
            8'h01:        begin tx_len_d = 6'd1;  rx_len_d = 6'd4;  end
            8'h02:        begin tx_len_d = 6'd3;  rx_len_d = 6'd33; end
            8'h03:        begin tx_len_d = 6'd35; rx_len_d = 6'd1;  end
            default: begin
              // Unknown command: finish at once without touching the lines.
              busy_d = 1'b0; state_d = S_IDLE;
              bad_d = 1'b1; done_d = 1'b1; tx_flush = 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end

    // Line engine
    case (state_q)
      S_TX_BIT: begin
        cyc_d = CNT_W'(cyc_q + 1'b1);
        if (cyc_q == C_BIT) begin
          cyc_d = '0;
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            if (nxt_idx == tx_len_q) state_d = S_TX_STOP;
            else begin
              byte_idx_d = nxt_idx;
              if (nxt_idx == 6'd1)      tx_sr_d = addr_hi_q;
              else if (nxt_idx == 6'd2) tx_sr_d = addr_lo_q;
              else if (tx_cnt_q != 6'd0) begin
                tx_sr_d = tx_mem[tx_rd_q]; tx_pop = 1'b1;
              end else tx_sr_d = 8'h00;  // short payload is zero padded
            end
          end
        end
      end
      S_TX_STOP: begin
        cyc_d = CNT_W'(cyc_q + 1'b1);
        if (cyc_q == C_STOP) begin cyc_d = '0; state_d = S_RX_WAIT; end
      end
      S_RX_WAIT: begin
        cyc_d = CNT_W'(cyc_q + 1'b1);
        if (fall) begin
          state_d = S_RX_BIT; pend_d = 1'b1; cyc_d = '0; bit_cnt_d = '0;
        end else if (cyc_q == C_TO) begin
          nores_d = 1'b1; state_d = S_DONE;
        end
      end
      S_RX_BIT: begin
        cyc_d = CNT_W'(cyc_q + 1'b1);
        if (pend_q) begin
          if (cyc_q == C_HALF) begin
            rx_sr_d = {rx_sr_q[6:0], sync_q[1]};
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            pend_d = 1'b0; cyc_d = '0;
            if (bit_cnt_q == 3'd7) begin
              rx_we = 1'b1; rx_wd = {rx_sr_q[6:0], sync_q[1]};
              rx_wr_d = 6'(rx_wr_q + 6'd1);
            end
          end
        end else if (fall) begin
          // Once every byte is in, the next low pulse is the device stop bit.
          if (rx_wr_q == rx_len_q) state_d = S_DONE;
          else begin pend_d = 1'b1; cyc_d = '0; end
        end else if (cyc_q == C_TO) begin
          nores_d = 1'b1; state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d = 1'b0; done_d = 1'b1; tx_flush = 1'b1; state_d = S_IDLE;
      end
      default: ;
    endcase

    if (tx_push) tx_wr_d = 5'(tx_wr_q + 5'd1);
    if (tx_pop)  tx_rd_d = 5'(tx_rd_q + 5'd1);
    tx_cnt_d = 6'(tx_cnt_q + {5'd0, tx_push} - {5'd0, tx_pop});
    if (tx_flush) begin tx_rd_d = '0; tx_wr_d = '0; tx_cnt_d = '0; end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= data_in_bus;
    if (rx_we)   rx_mem[rx_wr_q] <= rx_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; cyc_q <= '0; bit_cnt_q <= '0; byte_idx_q <= '0;
      tx_len_q <= '0; rx_len_q <= '0; tx_sr_q <= '0; rx_sr_q <= '0; pend_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; nores_q <= 1'b0; bad_q <= 1'b0; ovf_q <= 1'b0;
      port_q <= '0; cmd_q <= '0; addr_hi_q <= '0; addr_lo_q <= '0; dout_q <= '0;
      tx_rd_q <= '0; tx_wr_q <= '0; tx_cnt_q <= '0; rx_rd_q <= '0; rx_wr_q <= '0;
      sync_q <= 3'b111;
    end else begin
      state_q <= state_d; cyc_q <= cyc_d; bit_cnt_q <= bit_cnt_d; byte_idx_q <= byte_idx_d;
      tx_len_q <= tx_len_d; rx_len_q <= rx_len_d; tx_sr_q <= tx_sr_d; rx_sr_q <= rx_sr_d;
      pend_q <= pend_d; busy_q <= busy_d; done_q <= done_d; nores_q <= nores_d;
      bad_q <= bad_d; ovf_q <= ovf_d; port_q <= port_d; cmd_q <= cmd_d;
      addr_hi_q <= addr_hi_d; addr_lo_q <= addr_lo_d; dout_q <= dout_d;
      tx_rd_q <= tx_rd_d; tx_wr_q <= tx_wr_d; tx_cnt_q <= tx_cnt_d;
      rx_rd_q <= rx_rd_d; rx_wr_q <= rx_wr_d; sync_q <= sync_d;
    end
  end

endmodule

// File: tb/tb_n64_joybus_host.sv
// Testbench for n64_joybus_host: a behavioural controller model decodes the
// host's pulses into bytes and answers with randomised reply bytes. Expected
// line bytes, STATUS and RX contents come from the command table and a
// queue model of the TX FIFO.
module tb_n64_joybus_host;
  localparam int Q  = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = '0;
  logic [7:0] din = '0;
  logic       write = 1'b0, ce = 1'b0;
  logic [7:0] dout;
  logic [3:0] dev_drv = '0;
  wire joy1, joy2, joy3, joy4;

  assign joy1 = dev_drv[0] ? 1'b0 : 1'bz;
  assign joy2 = dev_drv[1] ? 1'b0 : 1'bz;
  assign joy3 = dev_drv[2] ? 1'b0 : 1'bz;
  assign joy4 = dev_drv[3] ? 1'b0 : 1'bz;
  pullup (joy1);
  pullup (joy2);
  pullup (joy3);
  pullup (joy4);

  n64_joybus_host #(.QUARTER(Q), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .joy1(joy1), .joy2(joy2), .joy3(joy3), .joy4(joy4),
    .address(address), .data_in_bus(din), .write(write), .ce(ce), .data_out_bus(dout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_tx[$], got_tx[$], reply[$], model_txq[$];
  logic       model_ovf;
  int         others_viol, stop_bit, tx_expired;

  function automatic logic line(input int p);
    case (p)
      0:       return joy1;
      1:       return joy2;
      2:       return joy3;
      default: return joy4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); address = a; din = d; write = 1'b1; ce = 1'b1;
    @(negedge clk); ce = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); address = a; write = 1'b0; ce = 1'b1;
    @(negedge clk); ce = 1'b0; d = dout;
  endtask

  task automatic push(input logic [7:0] d);
    wr(4'd6, d);
    if (model_txq.size() < 32) model_txq.push_back(d); else model_ovf = 1'b1;
  endtask

  // Bytes the host must put on the wire for a command, from the command table.
  task automatic build_tx(input logic [7:0] cmd, input logic [7:0] hi, input logic [7:0] lo);
    exp_tx.delete();
    exp_tx.push_back(cmd);
    if (cmd == 8'h02 || cmd == 8'h03) begin exp_tx.push_back(hi); exp_tx.push_back(lo); end
    if (cmd == 8'h03)
      for (int i = 0; i < 32; i++) exp_tx.push_back(i < model_txq.size() ? model_txq[i] : 8'h00);
  endtask

  // Controller model: decode nbytes*8 bits plus stop from pulse widths, then reply.
  task automatic run_device(input int p, input int nbytes);
    int bits[$];
    int low, budget;
    logic [7:0] b;
    low = 0; budget = 0; others_viol = 0; got_tx.delete();
    while (bits.size() < nbytes*8 + 1 && budget < 20000) begin
      @(negedge clk); budget++;
      for (int q = 0; q < 4; q++) if (q != p && line(q) !== 1'b1) others_viol++;
      if (line(p) === 1'b0) low++;
      else if (low > 0) begin bits.push_back((low < 2*Q) ? 1 : 0); low = 0; end
    end
    tx_expired = (budget >= 20000) ? 1 : 0;
    for (int i = 0; i < nbytes && (i*8 + 8) <= bits.size(); i++) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = (b << 1) | 8'(bits[i*8 + k]);
      got_tx.push_back(b);
    end
    stop_bit = (bits.size() > nbytes*8) ? bits[nbytes*8] : -1;
    if (reply.size() > 0) begin
      repeat (20) @(negedge clk);
      foreach (reply[i])
        for (int k = 7; k >= 0; k--) begin
          dev_drv[p] = 1'b1; repeat (reply[i][k] ? Q : 3*Q) @(negedge clk);
          dev_drv[p] = 1'b0; repeat (reply[i][k] ? 3*Q : Q) @(negedge clk);
        end
      dev_drv[p] = 1'b1; repeat (2*Q) @(negedge clk); dev_drv[p] = 1'b0;
    end
  endtask

  task automatic check_tx(input string tag);
    chk({tag, "_expired"}, 32'(tx_expired), 0);
    chk({tag, "_txlen"}, got_tx.size(), exp_tx.size());
    foreach (exp_tx[i]) chk({tag, "_txbyte"}, got_tx[i], exp_tx[i]);
    chk({tag, "_stop"}, 32'(stop_bit), 1);
    chk({tag, "_others"}, 32'(others_viol), 0);
  endtask

  task automatic finish_txn(input string tag, input int p);
    logic [7:0] v;
    repeat (3*Q + 10) @(negedge clk);
    rd(4'd3, v); chk({tag, "_status"}, v, 8'(p << 5) | 8'h02);
    foreach (reply[i]) begin rd(4'd5, v); chk({tag, "_rx"}, v, reply[i]); end
    rd(4'd5, v); chk({tag, "_rx_empty"}, v, 8'h00);
    model_txq.delete(); model_ovf = 1'b0;
  endtask

  initial begin
    logic [7:0] v, hi, lo, ctl;
    int p, n, lows;
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_dout", dout, 8'h00);
    rd(4'd3, v); chk("rst_status", v, 8'h00);
    rd(4'd5, v); chk("rst_rx_pop", v, 8'h00);
    chk("rst_lines", {joy4, joy3, joy2, joy1}, 4'hF);

    // Button read on joy1 with TX overflow beforehand
    wr(4'd0, 8'h01);
    for (int i = 1; i <= 33; i++) push(8'(i));
    wr(4'd1, 8'h22); wr(4'd2, 8'h35);
    rd(4'd3, v); chk("btn_ovf", v, {3'b000, model_ovf, 4'b0000});
    build_tx(8'h01, 8'h22, 8'h35);
    reply = '{(8'h1 << 7) | (8'h1 << 4), (8'h1 << 5) | (8'h1 << 4), 8'h05, 8'h04}; // A+Start, L+R, X, Y
    wr(4'd4, 8'h01);
    chk("btn_start_low", joy1, 1'b0);
    fork
      run_device(0, exp_tx.size());
      begin rd(4'd3, v); chk("btn_busy", v, 8'h01); end
    join
    check_tx("btn");
    finish_txn("btn", 0);

    // Status command on joy3
    wr(4'd0, 8'h00);
    build_tx(8'h00, 8'h22, 8'h35);
    reply = '{8'($urandom), 8'($urandom), 8'($urandom)};
    wr(4'd4, 8'h04);
    run_device(2, exp_tx.size());
    check_tx("stat");
    finish_txn("stat", 2);

    // No device on joy2
    wr(4'd0, 8'h01);
    build_tx(8'h01, 8'h22, 8'h35);
    reply.delete();
    wr(4'd4, 8'h02);
    run_device(1, exp_tx.size());
    check_tx("nodev");
    repeat (TO - 30) @(negedge clk);
    rd(4'd3, v); chk("nodev_busy", v, 8'h21);
    repeat (60) @(negedge clk);
    rd(4'd3, v); chk("nodev_status", v, 8'h26);
    rd(4'd5, v); chk("nodev_rx_empty", v, 8'h00);
    model_txq.delete();

    // Bad command
    wr(4'd0, 8'h55); wr(4'd4, 8'h01);
    rd(4'd3, v); chk("bad_status", v, 8'h0A);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({joy4, joy3, joy2, joy1} !== 4'hF) lows++;
    end
    chk("bad_lines", 32'(lows), 0);

    // Read RAM on a random port with random address and 33 reply bytes
    hi = 8'($urandom); lo = 8'($urandom); ctl = 8'($urandom_range(1, 15));
    p = 0; while (!ctl[p]) p++;
    wr(4'd0, 8'h02); wr(4'd1, hi); wr(4'd2, lo);
    build_tx(8'h02, hi, lo);
    reply.delete();
    for (int i = 0; i < 33; i++) reply.push_back(8'($urandom));
    wr(4'd4, ctl);
    run_device(p, exp_tx.size());
    check_tx("rdram");
    finish_txn("rdram", p);

    // Write RAM with 32 x 0xA5; a CTRL write while busy is ignored
    wr(4'd0, 8'h03); wr(4'd1, 8'h12); wr(4'd2, 8'h34);
    for (int i = 0; i < 32; i++) push(8'hA5);
    build_tx(8'h03, 8'h12, 8'h34);
    reply = '{8'($urandom)};
    wr(4'd4, 8'h01);
    fork
      run_device(0, exp_tx.size());
      begin
        repeat (60) @(negedge clk);
        wr(4'd4, 8'h02);
        rd(4'd3, v); chk("wram_busy_ignore", v, 8'h01);
      end
    join
    check_tx("wram");
    finish_txn("wram", 0);

    // Write RAM with a short random payload (zero padded)
    n = $urandom_range(0, 31);
    for (int i = 0; i < n; i++) push(8'($urandom));
    build_tx(8'h03, 8'h12, 8'h34);
    reply = '{8'($urandom)};
    wr(4'd4, 8'h08);
    run_device(3, exp_tx.size());
    check_tx("wpad");
    finish_txn("wpad", 3);

    // Reset in the middle of a transmission
    wr(4'd0, 8'h01);
    rd(4'd0, v); chk("pre_rst_cmd", v, 8'h01);
    wr(4'd4, 8'h01);
    repeat (3) @(negedge clk);
    chk("midrst_low", joy1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_lines", {joy4, joy3, joy2, joy1}, 4'hF);
    chk("midrst_dout", dout, 8'h00);
    rd(4'd3, v); chk("midrst_status", v, 8'h00);
    rd(4'd0, v); chk("midrst_cmd", v, 8'h00);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({joy4, joy3, joy2, joy1} !== 4'hF) lows++;
    end
    chk("midrst_idle", 32'(lows), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
